// File: rtl/mac_pkg.sv
// Shared constants and types for the multiply-accumulate stage.
package mac_pkg;

  localparam int unsigned ACC_W_DEF = 80;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned OPND_W    = 32;
  localparam int unsigned PROD_W    = 64;

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

endpackage

// File: rtl/mult_accumulator_if.sv
// Operand-in / result-out handshake bundle for mult_accumulator.
interface mult_accumulator_if
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [OPND_W-1:0] in_a;
  logic signed [OPND_W-1:0] in_b;
  logic                     in_last;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_acc;
  logic        [CNT_W-1:0]  out_count;
  logic                     out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );

endinterface

// File: rtl/mult_accumulator_multiplier.sv
// Combinational 32x32 signed multiplier feeding the accumulator's stage-1 register.
module Multiplier
  import mac_pkg::*;
(
  input  logic signed [OPND_W-1:0] a,
  input  logic signed [OPND_W-1:0] b,
  output logic signed [PROD_W-1:0] result
);

  assign result = a * b;

endmodule

// File: rtl/mult_accumulator.sv
// Two-stage signed multiply-accumulate: registered product, then wide accumulate
// with sticky overflow and a held result presented on the output handshake.
module mult_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mult_accumulator_if.slave bus
);

  state_t                   state, state_next;

  logic signed [PROD_W-1:0] mul_result;
  logic signed [PROD_W-1:0] prod_r;
  logic                     prod_v;
  logic                     prod_last;

  logic signed [ACC_W-1:0]  acc;
  logic        [CNT_W-1:0]  count;
  logic                     ovf;

  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic        [CNT_W-1:0]  count_next;
  logic                     ovf_next;
  logic                     accept;

  Multiplier u_mul (
    .a      (bus.in_a),
    .b      (bus.in_b),
    .result (mul_result)
  );

  assign bus.in_ready  = rst_n && (state == ACCUM) && !(prod_v && prod_last);
  assign bus.out_valid = (state == HOLD);
  assign accept        = bus.in_valid && bus.in_ready;

  always_comb begin
    prod_ext   = ACC_W'(prod_r);
    sum        = acc + prod_ext;
    // Signed overflow: both addends share a sign that the wrapped sum lacks.
    ovf_next   = ovf | ((acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                        (sum[ACC_W-1] != acc[ACC_W-1]));
    count_next = (count == {CNT_W{1'b1}}) ? count : count + 1'b1;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ACCUM: if (prod_v && prod_last) state_next = HOLD;
      HOLD:  if (bus.out_ready)       state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ACCUM;
      prod_r        <= '0;
      prod_v        <= 1'b0;
      prod_last     <= 1'b0;
      acc           <= '0;
      count         <= '0;
      ovf           <= 1'b0;
      bus.out_acc   <= '0;
      bus.out_count <= '0;
      bus.out_ovf   <= 1'b0;
    end else begin
      state  <= state_next;
      prod_v <= accept;
      if (accept) begin
        prod_r    <= mul_result;
        prod_last <= bus.in_last;
      end
      if (prod_v) begin
        if (prod_last) begin
          bus.out_acc   <= sum;
          bus.out_count <= count_next;
          bus.out_ovf   <= ovf_next;
          acc           <= '0;
          count         <= '0;
          ovf           <= 1'b0;
        end else begin
          acc   <= sum;
          count <= count_next;
          ovf   <= ovf_next;
        end
      end
    end
  end

endmodule
